// File: rtl/ex_stage_if.sv
// EX stage bundle: ID/EX operands and controls in, EX/MEM result and upstream stall out.
interface ex_stage_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] rdata_1_i;
    logic [31:0] rdata_2_i;
    logic [31:0] ext_imm_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic [31:0] wdata_o;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic        stall_o;

    modport master (
        output aluop_i, alusel_i, rdata_1_i, rdata_2_i, ext_imm_i, waddr_i, we_i,
        input  wdata_o, waddr_o, we_o, stall_o
    );
    modport slave (
        input  aluop_i, alusel_i, rdata_1_i, rdata_2_i, ext_imm_i, waddr_i, we_i,
        output wdata_o, waddr_o, we_o, stall_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/shift/compare, HI/LO registers, single-cycle
// MULT and a 32-cycle restoring signed divider that stalls upstream while busy.
module ex_stage (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);
    localparam logic [6:0] OP_SLL  = 7'h00, OP_SRL  = 7'h02, OP_SRA  = 7'h03;
    localparam logic [6:0] OP_MFHI = 7'h10, OP_MTHI = 7'h11, OP_MFLO = 7'h12, OP_MTLO = 7'h13;
    localparam logic [6:0] OP_MULT = 7'h18, OP_DIV  = 7'h1A;
    localparam logic [6:0] OP_ADD  = 7'h20, OP_ADDU = 7'h21, OP_SUB  = 7'h22;
    localparam logic [6:0] OP_AND  = 7'h24, OP_OR   = 7'h25, OP_XOR  = 7'h26, OP_NOR = 7'h27;
    localparam logic [6:0] OP_SLT  = 7'h2A, OP_SLTU = 7'h2B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  state, state_nx;
    logic [31:0] hi, lo;
    logic [31:0] dvd, dvs, rem;   // dvd shifts out dividend bits and fills with quotient bits
    logic [4:0]  cnt;
    logic        q_neg, r_neg;

    logic [6:0]  op;
    logic [31:0] a, b;
    logic [31:0] sum, diff, logic_res, shift_res, arith_res, move_res, class_res;
    logic        ovf, writes_rd, is_div, div_start, div_zero, stall;
    logic [63:0] prod;
    logic [31:0] rem_sh, rem_nx;
    logic        q_bit;

    assign op   = bus.aluop_i[6:0];
    assign a    = bus.rdata_1_i;
    assign b    = bus.aluop_i[7] ? bus.ext_imm_i : bus.rdata_2_i;
    assign sum  = a + b;
    assign diff = a - b;
    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    assign is_div    = (op == OP_DIV);
    assign div_start = (state == IDLE) && is_div && (b != 32'd0);
    assign div_zero  = (state == IDLE) && is_div && (b == 32'd0);
    assign stall     = div_start || (state == BUSY);

    // Restoring divider step on magnitudes: remainder < divisor <= 2^31 so 32 bits suffice.
    assign rem_sh = {rem[30:0], dvd[31]};
    assign q_bit  = (rem_sh >= dvs);
    assign rem_nx = q_bit ? rem_sh - dvs : rem_sh;

    // Per-class results; each class yields 0 for opcodes outside it.
    always_comb begin
        logic_res = 32'd0;
        shift_res = 32'd0;
        arith_res = 32'd0;
        move_res  = 32'd0;
        ovf       = 1'b0;
        writes_rd = 1'b0;
        case (op)
            OP_AND:  begin logic_res = a & b;    writes_rd = 1'b1; end
            OP_OR:   begin logic_res = a | b;    writes_rd = 1'b1; end
            OP_XOR:  begin logic_res = a ^ b;    writes_rd = 1'b1; end
            OP_NOR:  begin logic_res = ~(a | b); writes_rd = 1'b1; end
            OP_SLL:  begin shift_res = b << a[4:0]; writes_rd = 1'b1; end
            OP_SRL:  begin shift_res = b >> a[4:0]; writes_rd = 1'b1; end
            OP_SRA:  begin shift_res = $unsigned($signed(b) >>> a[4:0]); writes_rd = 1'b1; end
            OP_ADD:  begin arith_res = sum;  writes_rd = 1'b1; ovf = (a[31] == b[31]) && (sum[31] != a[31]); end
            OP_ADDU: begin arith_res = sum;  writes_rd = 1'b1; end
            OP_SUB:  begin arith_res = diff; writes_rd = 1'b1; ovf = (a[31] != b[31]) && (diff[31] != a[31]); end
            OP_SLT:  begin arith_res = {31'd0, $signed(a) < $signed(b)}; writes_rd = 1'b1; end
            OP_SLTU: begin arith_res = {31'd0, a < b}; writes_rd = 1'b1; end
            OP_MFHI: begin move_res = hi; writes_rd = 1'b1; end
            OP_MFLO: begin move_res = lo; writes_rd = 1'b1; end
            default: ;
        endcase
    end

    // Result class select and reset/stall gating of the outputs.
    always_comb begin
        class_res = 32'd0;
        case (bus.alusel_i)
            3'b001:  class_res = logic_res;
            3'b010:  class_res = shift_res;
            3'b011:  class_res = arith_res;
            3'b100:  class_res = move_res;
            default: class_res = 32'd0;
        endcase
        bus.wdata_o = rst ? class_res : 32'd0;
        bus.waddr_o = rst ? bus.waddr_i : 5'd0;
        bus.we_o    = rst && bus.we_i && writes_rd && !ovf && !stall;
        bus.stall_o = rst && stall;
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Divider next state; a DIV seen in DONE is the finishing one and does not restart.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (div_start) state_nx = BUSY;
            BUSY:    if (cnt == 5'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Divider datapath: capture magnitudes and signs on accept, one quotient bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dvd <= '0; dvs <= '0; rem <= '0; cnt <= '0; q_neg <= 1'b0; r_neg <= 1'b0;
        end else if (div_start) begin
            dvd   <= a[31] ? -a : a;
            dvs   <= b[31] ? -b : b;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= a[31] ^ b[31];
            r_neg <= a[31];
        end else if (state == BUSY) begin
            dvd <= {dvd[30:0], q_bit};
            rem <= rem_nx;
            cnt <= cnt + 5'd1;
        end
    end

    // HI/LO writes; divider completion wins over any same-cycle MULT/MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == DONE) begin
            hi <= r_neg ? -rem : rem;
            lo <= q_neg ? -dvd : dvd;
        end else if (div_zero) begin
            hi <= a;
            lo <= 32'hFFFF_FFFF;
        end else if (op == OP_MULT) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
        end else if (op == OP_MTHI) begin
            hi <= a;
        end else if (op == OP_MTLO) begin
            lo <= a;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors plus a randomized sweep against
// an arithmetic reference model of the ALU, HI/LO and divider.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result class of an opcode (0 = writes no register).
    function automatic logic [2:0] op_cls(input logic [6:0] op);
        case (op)
            7'h24, 7'h25, 7'h26, 7'h27:         return 3'd1;
            7'h00, 7'h02, 7'h03:                return 3'd2;
            7'h20, 7'h21, 7'h22, 7'h2A, 7'h2B:  return 3'd3;
            7'h10, 7'h12:                       return 3'd4;
            default:                            return 3'd0;
        endcase
    endfunction

    function automatic void model(input logic [7:0] aluop, input logic [2:0] sel,
                                  input logic [31:0] a, input logic [31:0] b, input logic we,
                                  output logic [31:0] wd, output logic wexp);
        int sa, sb, sh;
        longint t, p;
        logic [31:0] val;
        logic ovf;
        sa = a; sb = b; sh = {27'd0, a[4:0]};
        p = longint'(1) << sh;
        val = 32'd0; ovf = 1'b0; t = 0;
        case (aluop[6:0])
            7'h20: begin t = longint'(sa) + longint'(sb); ovf = (longint'(int'(t)) != t); val = t[31:0]; end
            7'h21: val = a + b;
            7'h22: begin t = longint'(sa) - longint'(sb); ovf = (longint'(int'(t)) != t); val = t[31:0]; end
            7'h24: val = a & b;
            7'h25: val = a | b;
            7'h26: val = a ^ b;
            7'h27: val = ~(a | b);
            7'h2A: val = (sa < sb) ? 32'd1 : 32'd0;
            7'h2B: val = (a < b) ? 32'd1 : 32'd0;
            7'h00: begin t = longint'(b) * p; val = t[31:0]; end
            7'h02: begin t = longint'(b) / p; val = t[31:0]; end
            7'h03: begin t = (sb >= 0) ? longint'(sb) / p : (longint'(sb) - p + 1) / p; val = t[31:0]; end
            7'h10: val = mhi;
            7'h12: val = mlo;
            default: val = 32'd0;
        endcase
        wd   = (op_cls(aluop[6:0]) != 3'd0 && sel == op_cls(aluop[6:0])) ? val : 32'd0;
        wexp = we && (op_cls(aluop[6:0]) != 3'd0) && !ovf;
    endfunction

    task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [4:0] wa, input logic we);
        bus.aluop_i = op; bus.alusel_i = sel; bus.rdata_1_i = a; bus.rdata_2_i = b;
        bus.ext_imm_i = imm; bus.waddr_i = wa; bus.we_i = we;
    endtask

    // Check the current (non-DIV) instruction against the model, clock it, then update model HI/LO.
    task automatic step(input string tag);
        logic [31:0] wd, b;
        logic wexp;
        longint pr;
        int sa, sb;
        b = bus.aluop_i[7] ? bus.ext_imm_i : bus.rdata_2_i;
        #2;
        model(bus.aluop_i, bus.alusel_i, bus.rdata_1_i, b, bus.we_i, wd, wexp);
        chk({tag, ".wdata"}, bus.wdata_o, wd);
        chk({tag, ".we"}, {31'd0, bus.we_o}, {31'd0, wexp});
        chk({tag, ".waddr"}, {27'd0, bus.waddr_o}, {27'd0, bus.waddr_i});
        chk({tag, ".stall"}, {31'd0, bus.stall_o}, 32'd0);
        @(posedge clk); #1;
        sa = bus.rdata_1_i; sb = b;
        case (bus.aluop_i[6:0])
            7'h18: begin pr = longint'(sa) * longint'(sb); mhi = pr[63:32]; mlo = pr[31:0]; end
            7'h11: mhi = bus.rdata_1_i;
            7'h13: mlo = bus.rdata_1_i;
            default: ;
        endcase
    endtask

    // Issue a held DIV, count stall cycles, then read HI/LO back through MFHI/MFLO.
    task automatic div_run(input string tag, input logic [31:0] a, input logic [31:0] b);
        int cnt, sa, sb;
        sa = a; sb = b;
        set_in(8'h1A, 3'b101, a, b, 32'd0, 5'd9, 1'b1);
        #2;
        cnt = 0;
        while (bus.stall_o === 1'b1 && cnt < 100) begin
            chk({tag, ".we_stall"}, {31'd0, bus.we_o}, 32'd0);
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, ".stall_cycles"}, cnt, (b == 32'd0) ? 32'd0 : 32'd33);
        chk({tag, ".we_div"}, {31'd0, bus.we_o}, 32'd0);
        @(posedge clk); #1;
        if (b == 32'd0) begin mhi = a; mlo = 32'hFFFF_FFFF; end
        else begin mhi = sa % sb; mlo = sa / sb; end
        set_in(8'h10, 3'b100, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1);
        step({tag, ".mfhi"});
        set_in(8'h12, 3'b100, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1);
        step({tag, ".mflo"});
    endtask

    logic [6:0] ops [22] = '{7'h20, 7'h21, 7'h22, 7'h24, 7'h25, 7'h26, 7'h27, 7'h2A, 7'h2B,
                             7'h00, 7'h02, 7'h03, 7'h10, 7'h12, 7'h11, 7'h13, 7'h18,
                             7'h01, 7'h30, 7'h7F, 7'h18, 7'h03};

    initial begin
        logic [6:0] op;
        logic [2:0] sel;
        logic [31:0] ra, rb;
        // Reset: outputs held at zero regardless of inputs.
        set_in(8'h21, 3'b011, 32'd3, 32'd4, 32'd0, 5'd5, 1'b1);
        #2;
        chk("rst.wdata", bus.wdata_o, 32'd0);
        chk("rst.waddr", {27'd0, bus.waddr_o}, 32'd0);
        chk("rst.we", {31'd0, bus.we_o}, 32'd0);
        chk("rst.stall", {31'd0, bus.stall_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        set_in(8'h10, 3'b100, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1); step("rst.hi");
        set_in(8'h12, 3'b100, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1); step("rst.lo");

        // Overflow suppression on ADD only.
        set_in(8'h20, 3'b011, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd7, 1'b1);
        #1 chk("add_ovf.wdata", bus.wdata_o, 32'h8000_0000);
        chk("add_ovf.we", {31'd0, bus.we_o}, 32'd0);
        step("add_ovf");
        set_in(8'h21, 3'b011, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd7, 1'b1);
        #1 chk("addu.we", {31'd0, bus.we_o}, 32'd1);
        step("addu");

        // Shift and compare vectors; immediate form of SRA too.
        set_in(8'h03, 3'b010, 32'd4, 32'h8000_0000, 32'd0, 5'd2, 1'b1);
        #1 chk("sra.wdata", bus.wdata_o, 32'hF800_0000);
        step("sra");
        set_in(8'h83, 3'b010, 32'd4, 32'd0, 32'h8000_0000, 5'd2, 1'b1); step("srai");
        set_in(8'h00, 3'b010, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd2, 1'b1); step("sll0");
        set_in(8'h2A, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2, 1'b1);
        #1 chk("slt.wdata", bus.wdata_o, 32'd1);
        step("slt");
        set_in(8'h2B, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2, 1'b1);
        #1 chk("sltu.wdata", bus.wdata_o, 32'd0);
        step("sltu");
        set_in(8'h24, 3'b010, 32'hFFFF_FFFF, 32'hFF, 32'd0, 5'd2, 1'b1); step("wrong_class");

        // MULT then HI/LO readback.
        set_in(8'h18, 3'b101, 32'hFFFF_FFFD, 32'd7, 32'd0, 5'd2, 1'b1); step("mult");
        set_in(8'h10, 3'b100, 32'd0, 32'd0, 32'd0, 5'd2, 1'b1);
        #1 chk("mult.hi", bus.wdata_o, 32'hFFFF_FFFF);
        step("mult.mfhi");
        set_in(8'h12, 3'b100, 32'd0, 32'd0, 32'd0, 5'd2, 1'b1);
        #1 chk("mult.lo", bus.wdata_o, 32'hFFFF_FFEB);
        step("mult.mflo");

        // Divider: signed case, divide by zero.
        div_run("div_m7_2", 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2.lo", mlo, 32'hFFFF_FFFD);
        chk("div_m7_2.hi", mhi, 32'hFFFF_FFFF);
        div_run("div_by0", 32'd5, 32'd0);

        // Reset in BUSY cycle 10 aborts; a re-issued DIV restarts cleanly.
        set_in(8'h1A, 3'b101, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd9, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("abort.stall_in_rst", {31'd0, bus.stall_o}, 32'd0);
        chk("abort.wdata_in_rst", bus.wdata_o, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        mhi = 32'd0; mlo = 32'd0;
        set_in(8'h10, 3'b100, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1); step("abort.hi");
        set_in(8'h12, 3'b100, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1); step("abort.lo");
        div_run("div_100_7", 32'd100, 32'd7);
        chk("div_100_7.lo", mlo, 32'd14);
        chk("div_100_7.hi", mhi, 32'd2);

        // Randomized sweep over all non-DIV opcodes against the model.
        for (int i = 0; i < 200; i++) begin
            op  = ops[$urandom_range(0, 21)];
            sel = ($urandom_range(0, 9) < 7) ? op_cls(op) : 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
            set_in({1'($urandom_range(0, 1)), op}, sel, ra, rb, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
            step("rand");
        end
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0 || (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) rb = 32'd3;
            div_run("rand_div", ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- aluop_i  in  8  operation code
- alusel_i  in  3  result class
- rdata_1_i  in  32  operand A
- rdata_2_i  in  32  operand B (register)
- ext_imm_i  in  32  extended immediate
- waddr_i  in  5  destination register
- we_i  in  1  write enable from ID/EX
- wdata_o  out  32  result
- waddr_o  out  5  destination register
- we_o  out  1  write enable to EX/MEM
- stall_o  out  1  pipeline hold request to upstream stages
REQ-002 Reset SHALL be rst, synchronous, active-low; the clock SHALL be clk.

Function
REQ-003 aluop encodings SHALL be as follows; all other codes are NOP (wdata_o=0, we_o=0):
- ADD 8'h20, ADDU 8'h21, SUB 8'h22, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27, SLT 8'h2A, SLTU 8'h2B
- SLL 8'h00, SRL 8'h02, SRA 8'h03
- MFHI 8'h10, MFLO 8'h12, MTHI 8'h11, MTLO 8'h13
- MULT 8'h18, DIV 8'h1A
REQ-004 The immediate form SHALL be aluop_i[7]=1, with aluop_i[6:0] selecting the base operation from REQ-003; operand B = ext_imm_i in that case, else rdata_2_i.
REQ-005 alusel_i SHALL be 3'b001 logic, 3'b010 shift, 3'b011 arith, 3'b100 HI/LO move, 3'b101 mul/div; wdata_o SHALL come from the selected class only, 0 otherwise.
REQ-006 Shifts SHALL shift operand B by rdata_1_i[4:0]; SRA SHALL sign-fill; an amount of 0 SHALL pass operand B unchanged.
REQ-007 SLT SHALL compare signed and SLTU unsigned; wdata_o SHALL be 32'd1 or 32'd0.
REQ-008 ADD/SUB SHALL detect two's-complement overflow and force we_o=0 on overflow; ADDU SHALL never suppress.
REQ-009 wdata_o, waddr_o and we_o SHALL be combinational from the current inputs and HI/LO state; waddr_o SHALL equal waddr_i.
REQ-010 HI and LO SHALL be 32-bit registers:
- MTHI/MTLO write rdata_1_i at the clock edge.
- MFHI/MFLO read the registered value (no same-cycle bypass).
REQ-011 MULT SHALL write the signed 64-bit product {HI,LO} at the edge of the presenting cycle, with latency 1.
REQ-012 DIV SHALL be signed, via a 32-iteration restoring divider on operand magnitudes. The quotient sign SHALL be A^B and the remainder sign SHALL be the sign of A. The quotient SHALL go to LO and the remainder to HI.
REQ-013 The divider FSM SHALL use states IDLE, BUSY and DONE:
- IDLE + DIV with B!=0 -> BUSY: capture operands, counter=0.
- BUSY: one quotient bit per cycle; counter reaching 31 -> DONE.
- DONE: write HI/LO at the edge -> IDLE.
REQ-014 stall_o SHALL be 1 in the IDLE accept cycle and in all 32 BUSY cycles (33 cycles total), and 0 in DONE. Upstream holds inputs stable while stall_o=1.
REQ-015 DIV with B=0 SHALL complete in the presenting cycle with HI=A and LO=32'hFFFFFFFF, with no stall.
REQ-016 we_o SHALL be 0 for MULT, DIV, MTHI, MTLO, NOP, and every cycle stall_o=1, regardless of we_i.
REQ-017 A DIV presented while in DONE SHALL be treated as the completing instruction and SHALL NOT restart the FSM.
REQ-018 When MULT/MTHI/MTLO and divider completion coincide, the divider write SHALL take priority. This cannot occur with legal stalling; it is defined for robustness only.

Reset
REQ-019 While rst=0 at a clock edge, the module SHALL set HI=0, LO=0, FSM=IDLE, counter=0 and all divider operand/partial registers to 0.
REQ-020 While rst=0, the outputs SHALL be wdata_o=0, waddr_o=0, we_o=0 and stall_o=0.
REQ-021 Reset asserted mid-division SHALL abort the operation with HI/LO left at 0; a DIV presented after reset SHALL restart from IDLE.

Verification
REQ-022 ADD A=32'h7FFFFFFF, B=1, we_i=1 -> wdata_o=32'h80000000, we_o=0; ADDU with the same operands -> we_o=1.
REQ-023 SRA B=32'h80000000, rdata_1_i=4 -> 32'hF8000000; SLT A=-1, B=1 -> 1; SLTU with the same operands -> 0.
REQ-024 MULT A=-3, B=7 then MFHI, MFLO -> 32'hFFFFFFFF, 32'hFFFFFFEB; we_o=0 on the MULT cycle.
REQ-025 DIV A=-7, B=2 held -> stall_o=1 for exactly 33 cycles, 0 on the 34th; then LO=32'hFFFFFFFD (-3) and HI=32'hFFFFFFFF (-1).
REQ-026 DIV B=0, A=5 -> no stall, HI=5, LO=32'hFFFFFFFF on the next cycle.
REQ-027 rst=0 at BUSY cycle 10 -> stall_o=0 and HI=LO=0 next cycle; a re-issued DIV 100/7 -> LO=14, HI=2 after 33 stall cycles.
